ofmap_drain: RTL and testbench
==============================

# ofmap_drain

Read-out stage directly downstream of the GEMM core. After GEMM signals completion, the block drains the ofmap BRAM (mem2) through its second port. It streams every 112-bit word (14 packed 8-bit lanes) out over a valid/ready interface at up to one word per clock. A 2-entry output buffer absorbs the BRAM's 1-cycle read latency so that backpressure never loses or duplicates data.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one ofmap element
- PE_SIZE, 14, elements per BRAM word
- MEM2_DATA_WIDTH, 112, BRAM word width; must equal DATA_WIDTH*PE_SIZE
- MEM2_DEPTH, 896, number of words drained per run
- MEM2_ADDR_WIDTH, 10, BRAM address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle pulse, normally driven by GEMM finish_o
- mem2_ce1  out  1  BRAM port-1 chip enable
- mem2_we1  out  1  BRAM port-1 write enable; tied 0
- mem2_addr1  out  MEM2_ADDR_WIDTH  BRAM port-1 read address
- mem2_q1_i  in  MEM2_DATA_WIDTH  BRAM port-1 read data, valid 1 cycle after ce
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  MEM2_DATA_WIDTH  word; lane 0 in bits [111:104], lane 13 in bits [7:0]
- out_last_o  out  1  high with the word read from address MEM2_DEPTH-1
- busy_o  out  1  high from start acceptance until done_o
- done_o  out  1  one-cycle pulse after the last handshake

## Operation
- FSM states and transitions:
  - IDLE: start_i moves to READ and clears the address and word counters.
  - READ: issues reads and moves to FLUSH after issuing address MEM2_DEPTH-1.
  - FLUSH: moves to DONE when the buffer is empty and no read is in flight.
  - DONE: pulses done_o for 1 cycle, then returns to IDLE.
- start_i is ignored outside IDLE.
- Read issue: in READ, assert mem2_ce1 with the current addr when `occupancy + inflight - pop < 2`, where pop = out_valid_o & out_ready_i. After each issue, addr increments by 1.
- Capture: the cycle after an issue, mem2_q1_i is pushed into the buffer (inflight = 1-bit registered copy of mem2_ce1).
- The buffer is a 2-entry FIFO. out_data_o, out_valid_o and out_last_o come from the head entry and are registered; there is no combinational path from mem2_q1_i.
- out_valid_o stays asserted and out_data_o stays stable until a handshake occurs.
- The block never issues a read while the buffer is full. Push and pop in the same cycle are allowed.
- A 10-bit word counter of handshakes sets out_last_o on the word with index MEM2_DEPTH-1.
- rst in any state returns to IDLE and clears the buffer, inflight and all outputs. Read data arriving the cycle after reset is discarded.

## Timing
- Reset values: mem2_ce1=0, mem2_we1=0, mem2_addr1=0, out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, done_o=0.
- Let cycle 0 be the cycle in which start_i is sampled high in IDLE.
  - busy_o=1 from cycle 1.
  - First read (ce=1, addr=0) in cycle 1.
  - First data captured at the end of cycle 2.
  - out_valid_o=1 from cycle 3.
- With out_ready_i held high: one word per cycle, cycles 3 to 898; out_last_o in cycle 898; done_o in cycle 899; busy_o falls in cycle 900.
- Backpressure: once out_ready_i falls, ce deasserts by the cycle after the buffer fills. Resuming ready restores full rate without a bubble beyond the 1-cycle read latency.
- Address never exceeds MEM2_DEPTH-1 and does not wrap.
- Latency from start to first valid is fixed at 3 cycles.

## Test plan
- Fill mem2 with word k = {14{k[7:0]}}, pulse start, hold ready=1 -> 896 words in order on cycles 3..898, last only on word 895, done at cycle 899.
- Ready toggles 1,0,1,0 -> every word appears exactly once, in order; data stays stable while ready=0; 896 handshakes total.
- Ready=0 for 50 cycles after start -> at most 2 reads issued, mem2_ce1=0 from cycle 3 until ready rises, then the stream resumes with no loss.
- Pulse start again at cycle 100 of a run -> it is ignored; addresses remain monotonic; exactly one done pulse.
- Assert rst at handshake 300 -> next cycle all outputs 0 and state IDLE; a new start drains from addr 0 with word 0 first.
- mem2_we1 is checked as 0 throughout; mem2_addr1 never exceeds 895.

Source files
------------

// File: rtl/ofmap_drain.sv
// Drains the ofmap BRAM (mem2) after GEMM completes and streams each word over valid/ready.
// A two-entry output buffer hides the one-cycle BRAM read latency under backpressure.
module ofmap_drain #(
  parameter int DATA_WIDTH      = 8,
  parameter int PE_SIZE         = 14,
  parameter int MEM2_DATA_WIDTH = 112,
  parameter int MEM2_DEPTH      = 896,
  parameter int MEM2_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       mem2_ce1,
  output logic                       mem2_we1,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1,
  input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [MEM2_DATA_WIDTH-1:0] out_data_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // READ  | issuing reads while the buffer has room
  // FLUSH | all reads issued; waiting for buffer and in-flight read to empty
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  localparam int AW = MEM2_ADDR_WIDTH;
  localparam int DW = MEM2_DATA_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM2_DEPTH - 1);

  if (MEM2_DATA_WIDTH != DATA_WIDTH * PE_SIZE) begin : g_width_check
    $error("MEM2_DATA_WIDTH must equal DATA_WIDTH*PE_SIZE");
  end

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] cnt_q;
  logic          inflight_q;

  // Head entry drives the outputs directly; skid holds the second entry.
  logic          head_valid_q, head_valid_d;
  logic          head_last_q, head_last_d;
  logic [DW-1:0] head_data_q, head_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  logic          pop;
  logic          push;
  logic          issue;
  logic [1:0]    occ;
  logic [AW-1:0] head_idx;

  assign pop      = head_valid_q & out_ready_i;
  assign push     = inflight_q;
  assign occ      = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
  assign issue    = (state_q == READ) &&
                    (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  assign head_idx = cnt_q + {{(AW-1){1'b0}}, pop};

  assign mem2_ce1    = issue;
  assign mem2_we1    = 1'b0;
  assign mem2_addr1  = addr_q;
  assign out_valid_o = head_valid_q;
  assign out_data_o  = head_data_q;
  assign out_last_o  = head_last_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  always_comb begin
    head_valid_d = head_valid_q;
    head_last_d  = head_last_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop || !head_valid_q) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        head_last_d  = (head_idx == LAST_ADDR);
        skid_valid_d = push;
        if (push) skid_data_d = mem2_q1_i;
      end else if (push) begin
        head_valid_d = 1'b1;
        head_data_d  = mem2_q1_i;
        head_last_d  = (head_idx == LAST_ADDR);
      end else begin
        head_valid_d = 1'b0;
        head_last_d  = 1'b0;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = mem2_q1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      head_valid_q <= 1'b0;
      head_last_q  <= 1'b0;
      head_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      inflight_q   <= issue;
      head_valid_q <= head_valid_d;
      head_last_q  <= head_last_d;
      head_data_q  <= head_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      if (pop) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= READ;
            addr_q  <= '0;
            cnt_q   <= '0;
          end
        end
        READ: begin
          // Address parks on the last word rather than stepping past the end.
          if (issue) begin
            if (addr_q == LAST_ADDR) state_q <= FLUSH;
            else                     addr_q  <= addr_q + 1'b1;
          end
        end
        FLUSH: begin
          if (!head_valid_d && !skid_valid_d) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_drain.sv
// Directed bench for ofmap_drain: BRAM model holds word k = {14{k[7:0]}}, scenarios check
// cycle timing, backpressure, ignored restart and mid-run reset.
module tb_ofmap_drain;
  localparam int DW = 112;
  localparam int AW = 10;
  localparam int DEPTH = 896;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          mem2_ce1, mem2_we1;
  logic [AW-1:0] mem2_addr1;
  logic [DW-1:0] mem2_q1_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic          out_last_o, busy_o, done_o;

  int vectors = 0;
  int errors  = 0;

  ofmap_drain dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .mem2_ce1(mem2_ce1), .mem2_we1(mem2_we1), .mem2_addr1(mem2_addr1), .mem2_q1_i(mem2_q1_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {14{b}};
  endfunction

  always @(posedge clk) if (mem2_ce1) mem2_q1_i <= word(int'(mem2_addr1));

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (mem2_ce1 !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", mem2_ce1); end
    vectors++; if (mem2_we1 !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem2_we1); end
    vectors++; if (mem2_addr1 !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem2_addr1); end
    vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    vectors++; if (out_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data_o); end
    vectors++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last_o); end
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    vectors++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_rate();
    logic exp_valid;
    out_ready_i = 1'b1;
    pulse_start();
    for (int c = 1; c <= 901; c++) begin
      @(negedge clk);
      exp_valid = (c >= 3 && c <= 898);
      vectors++; if (mem2_we1 !== 1'b0 || mem2_addr1 > AW'(DEPTH - 1)) begin errors++; $display("FAIL full_port c=%0d: we=%b addr=%0d expected we=0 addr<=895", c, mem2_we1, mem2_addr1); end
      vectors++; if (mem2_ce1 !== (c <= 896)) begin errors++; $display("FAIL full_ce c=%0d: got %b expected %b", c, mem2_ce1, (c <= 896)); end
      if (c <= 896) begin
        vectors++; if (mem2_addr1 !== AW'(c - 1)) begin errors++; $display("FAIL full_addr c=%0d: got %0d expected %0d", c, mem2_addr1, c - 1); end
      end
      vectors++; if (out_valid_o !== exp_valid) begin errors++; $display("FAIL full_valid c=%0d: got %b expected %b", c, out_valid_o, exp_valid); end
      if (exp_valid) begin
        vectors++; if (out_data_o !== word(c - 3)) begin errors++; $display("FAIL full_data c=%0d: got %h expected %h", c, out_data_o, word(c - 3)); end
      end
      vectors++; if (out_last_o !== (c == 898)) begin errors++; $display("FAIL full_last c=%0d: got %b expected %b", c, out_last_o, (c == 898)); end
      vectors++; if (done_o !== (c == 899)) begin errors++; $display("FAIL full_done c=%0d: got %b expected %b", c, done_o, (c == 899)); end
      vectors++; if (busy_o !== (c <= 899)) begin errors++; $display("FAIL full_busy c=%0d: got %b expected %b", c, busy_o, (c <= 899)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_toggle();
    int k = 0;
    logic hold = 1'b0;
    logic seen_done = 1'b0;
    logic [DW-1:0] held = '0;
    out_ready_i = 1'b0;
    pulse_start();
    for (int c = 1; c <= 3000; c++) begin
      out_ready_i = (c % 2 == 1);
      @(negedge clk);
      vectors++; if (mem2_we1 !== 1'b0 || mem2_addr1 > AW'(DEPTH - 1)) begin errors++; $display("FAIL toggle_port c=%0d: we=%b addr=%0d expected we=0 addr<=895", c, mem2_we1, mem2_addr1); end
      if (hold) begin
        vectors++; if (out_valid_o !== 1'b1 || out_data_o !== held) begin errors++; $display("FAIL toggle_stable c=%0d: valid=%b data=%h expected valid=1 data=%h", c, out_valid_o, out_data_o, held); end
      end
      hold = 1'b0;
      if (out_valid_o && out_ready_i) begin
        vectors++; if (out_data_o !== word(k) || out_last_o !== (k == DEPTH - 1)) begin errors++; $display("FAIL toggle_word %0d: data=%h last=%b expected data=%h last=%b", k, out_data_o, out_last_o, word(k), (k == DEPTH - 1)); end
        k++;
      end else if (out_valid_o) begin
        hold = 1'b1;
        held = out_data_o;
      end
      if (done_o) begin seen_done = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vectors++; if (k !== DEPTH) begin errors++; $display("FAIL toggle_count: got %0d handshakes expected %0d", k, DEPTH); end
    vectors++; if (seen_done !== 1'b1) begin errors++; $display("FAIL toggle_done: got %b expected 1 within budget", seen_done); end
  endtask

  task automatic test_stall();
    int k = 0;
    int ce_cnt = 0;
    logic seen_done = 1'b0;
    out_ready_i = 1'b0;
    pulse_start();
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (mem2_ce1) ce_cnt++;
      if (c >= 3) begin
        vectors++; if (mem2_ce1 !== 1'b0) begin errors++; $display("FAIL stall_ce c=%0d: got %b expected 0", c, mem2_ce1); end
      end
      if (c == 50) begin
        vectors++; if (out_valid_o !== 1'b1 || out_data_o !== word(0)) begin errors++; $display("FAIL stall_head: valid=%b data=%h expected valid=1 data=%h", out_valid_o, out_data_o, word(0)); end
      end
      @(posedge clk); #1;
    end
    vectors++; if (ce_cnt !== 2) begin errors++; $display("FAIL stall_reads: got %0d reads expected 2", ce_cnt); end
    out_ready_i = 1'b1;
    for (int c = 51; c <= 2000; c++) begin
      @(negedge clk);
      vectors++; if (mem2_we1 !== 1'b0 || mem2_addr1 > AW'(DEPTH - 1)) begin errors++; $display("FAIL stall_port c=%0d: we=%b addr=%0d expected we=0 addr<=895", c, mem2_we1, mem2_addr1); end
      if (out_valid_o) begin
        vectors++; if (out_data_o !== word(k) || out_last_o !== (k == DEPTH - 1)) begin errors++; $display("FAIL stall_word %0d: data=%h last=%b expected data=%h last=%b", k, out_data_o, out_last_o, word(k), (k == DEPTH - 1)); end
        k++;
      end
      if (done_o) begin seen_done = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vectors++; if (k !== DEPTH) begin errors++; $display("FAIL stall_count: got %0d words expected %0d", k, DEPTH); end
    vectors++; if (seen_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1 within budget", seen_done); end
  endtask

  task automatic test_restart_ignored();
    int k = 0;
    int last_addr = -1;
    int done_cnt = 0;
    out_ready_i = 1'b1;
    pulse_start();
    for (int c = 1; c <= 1100; c++) begin
      start_i = (c == 100);
      @(negedge clk);
      vectors++; if (mem2_we1 !== 1'b0 || mem2_addr1 > AW'(DEPTH - 1)) begin errors++; $display("FAIL restart_port c=%0d: we=%b addr=%0d expected we=0 addr<=895", c, mem2_we1, mem2_addr1); end
      if (mem2_ce1) begin
        vectors++; if (int'(mem2_addr1) !== last_addr + 1) begin errors++; $display("FAIL restart_addr c=%0d: got %0d expected %0d", c, mem2_addr1, last_addr + 1); end
        last_addr = int'(mem2_addr1);
      end
      if (out_valid_o) begin
        vectors++; if (out_data_o !== word(k)) begin errors++; $display("FAIL restart_word %0d: got %h expected %h", k, out_data_o, word(k)); end
        k++;
      end
      if (done_o) done_cnt++;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
    vectors++; if (k !== DEPTH) begin errors++; $display("FAIL restart_count: got %0d words expected %0d", k, DEPTH); end
    vectors++; if (last_addr !== DEPTH - 1) begin errors++; $display("FAIL restart_last_addr: got %0d expected %0d", last_addr, DEPTH - 1); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int first_c = -1;
    logic hit = 1'b0;
    logic seen_done = 1'b0;
    out_ready_i = 1'b1;
    pulse_start();
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (out_valid_o) begin
        if (k == 300) begin rst = 1'b1; hit = 1'b1; break; end
        k++;
      end
      @(posedge clk); #1;
    end
    vectors++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach: got %b expected handshake 300 reached", hit); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if ({mem2_ce1, out_valid_o, out_last_o, busy_o, done_o} !== 5'b0) begin errors++; $display("FAIL rstmid_ctrl: ce,valid,last,busy,done=%b expected 00000", {mem2_ce1, out_valid_o, out_last_o, busy_o, done_o}); end
    vectors++; if (mem2_addr1 !== '0 || out_data_o !== '0) begin errors++; $display("FAIL rstmid_zero: addr=%0d data=%h expected 0 and 0", mem2_addr1, out_data_o); end
    @(posedge clk); #1;
    k = 0;
    pulse_start();
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (out_valid_o) begin
        if (first_c < 0) first_c = c;
        vectors++; if (out_data_o !== word(k) || out_last_o !== (k == DEPTH - 1)) begin errors++; $display("FAIL rstmid_word %0d: data=%h last=%b expected data=%h last=%b", k, out_data_o, out_last_o, word(k), (k == DEPTH - 1)); end
        k++;
      end
      if (done_o) begin seen_done = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vectors++; if (first_c !== 3) begin errors++; $display("FAIL rstmid_latency: first valid at cycle %0d expected 3", first_c); end
    vectors++; if (k !== DEPTH) begin errors++; $display("FAIL rstmid_count: got %0d words expected %0d", k, DEPTH); end
    vectors++; if (seen_done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b expected 1 within budget", seen_done); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    repeat (3) @(posedge clk); #1;
    test_toggle();
    repeat (3) @(posedge clk); #1;
    test_stall();
    repeat (3) @(posedge clk); #1;
    test_restart_ignored();
    repeat (3) @(posedge clk); #1;
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
